// File: rtl/servo_pwm_gen.sv
// Servo PWM generator. Once per frame it samples the position command,
// turns it into a clamped pulse width, and drives a registered PWM output
// together with a one-cycle frame strobe for the upstream command register.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped; pwm low; waiting for enable to start a frame
// ALTO  | pulse high; counting up to the latched width
// BAJO  | pulse low; counting to the end of the frame
module servo_pwm_gen #(
   parameter int N          = 16,
   parameter int CNT_W      = 20,
   parameter int PERIOD_CYC = 1000000,
   parameter int MIN_CYC    = 50000,
   parameter int MAX_CYC    = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [N-1:0]     dato_entrada,
   output logic             pwm_out,
   output logic             period_tick,
   output logic [CNT_W-1:0] ancho_actual,
   output logic             sat
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ALTO = 2'd1,
      BAJO = 2'd2
   } state_t;

   // Sum is formed wide enough for both the command and the counter, so a
   // large command can never wrap around and slip under the clamp.
   localparam int SUM_W = ((N > CNT_W) ? N : CNT_W) + 1;
   localparam logic [SUM_W-1:0] MIN_EXT  = SUM_W'(MIN_CYC);
   localparam logic [SUM_W-1:0] MAX_EXT  = SUM_W'(MAX_CYC);
   localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MAX_CYC);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pwm_q, pwm_d;
   logic              tick_q, tick_d;
   logic [CNT_W-1:0]  ancho_q, ancho_d;
   logic              sat_q, sat_d;

   logic [SUM_W-1:0]  width_sum;
   logic [CNT_W-1:0]  width_c;
   logic              sat_c;
   logic              frame_end;
   logic              start;

   // Clamp MIN_CYC + command to MAX_CYC; only latched at a frame start.
   always_comb begin
      width_sum = MIN_EXT + SUM_W'(dato_entrada);
      width_c   = width_sum[CNT_W-1:0];
      sat_c     = 1'b0;
      if (width_sum > MAX_EXT) begin
         width_c = MAX_W;
         sat_c   = 1'b1;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pwm_d     = pwm_q;
      tick_d    = 1'b0;
      ancho_d   = ancho_q;
      sat_d     = sat_q;
      frame_end = (cnt_q == LAST_CNT);
      start     = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            pwm_d = 1'b0;
            if (enable) start = 1'b1;
         end
         ALTO: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == ancho_q - CNT_W'(1)) begin
               state_d = BAJO;
               pwm_d   = 1'b0;
            end
         end
         BAJO: begin
            if (frame_end) begin
               if (enable) begin
                  start = 1'b1;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  sat_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            pwm_d   = 1'b0;
         end
      endcase

      if (start) begin
         state_d = ALTO;
         cnt_d   = '0;
         pwm_d   = 1'b1;
         tick_d  = 1'b1;
         ancho_d = width_c;
         sat_d   = sat_c;
      end
   end

   // State and output registers; reset clears every output at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pwm_q   <= 1'b0;
         tick_q  <= 1'b0;
         ancho_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pwm_q   <= pwm_d;
         tick_q  <= tick_d;
         ancho_q <= ancho_d;
         sat_q   <= sat_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_tick  = tick_q;
   assign ancho_actual = ancho_q;
   assign sat          = sat_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: a frame-level reference model checked every
// cycle, a table of command/width vectors, directed corner sequences and
// a randomized run.
module tb_servo_pwm_gen;

   localparam int N      = 8;
   localparam int CNT_W  = 8;
   localparam int PERIOD = 100;
   localparam int MINC   = 10;
   localparam int MAXC   = 20;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [N-1:0]     dato;
   logic             pwm_out;
   logic             period_tick;
   logic [CNT_W-1:0] ancho_actual;
   logic             sat;

   servo_pwm_gen #(
      .N(N), .CNT_W(CNT_W), .PERIOD_CYC(PERIOD), .MIN_CYC(MINC), .MAX_CYC(MAXC)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .dato_entrada(dato),
      .pwm_out(pwm_out), .period_tick(period_tick),
      .ancho_actual(ancho_actual), .sat(sat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: is a frame running, which clock of the frame we are
   // on, and the width/saturation chosen when the frame began.
   bit m_run;
   int m_pos;
   int m_w;
   bit m_sat;

   function automatic int ref_width(input int d);
      return (MINC + d > MAXC) ? MAXC : MINC + d;
   endfunction

   task automatic m_clear();
      m_run = 0; m_pos = 0; m_w = 0; m_sat = 0;
   endtask

   task automatic m_start(input int d);
      m_run = 1; m_pos = 0; m_w = ref_width(d); m_sat = (MINC + d > MAXC);
   endtask

   task automatic m_edge();
      if (!reset) m_clear();
      else if (!m_run) begin
         if (enable) m_start(int'(dato));
      end else if (m_pos == PERIOD - 1) begin
         if (enable) m_start(int'(dato));
         else begin
            m_run = 0;
            m_sat = 0;
         end
      end else m_pos++;
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_pwm"},   int'(pwm_out),      int'(m_run && m_pos < m_w));
      check({tag, "_tick"},  int'(period_tick),  int'(m_run && m_pos == 0));
      check({tag, "_ancho"}, int'(ancho_actual), m_w);
      check({tag, "_sat"},   int'(sat),          int'(m_sat));
   endtask

   task automatic cyc();
      @(posedge clk);
      m_edge();
      #1;
      compare_all("cyc");
   endtask

   task automatic sync_start(input string tag);
      int n = 0;
      do begin
         cyc();
         n++;
      end while (!(m_run && m_pos == 0) && n < 250);
      check({tag, "_sync_tick"}, int'(period_tick), 1);
   endtask

   // Observes one frame starting at its clock 0 (already sampled).
   task automatic measure(output int hi, output int tk,
                          input int change_at, input int new_d, input int drop_at);
      hi = 0; tk = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (i > 0) cyc();
         hi += int'(pwm_out);
         tk += int'(period_tick);
         if (i == change_at) dato = N'(new_d);
         if (i == drop_at) enable = 1'b0;
      end
   endtask

   typedef struct {
      int d;
      int exp_w;
      bit exp_sat;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int hi, tk, hi2, tk2;

      tbl[0] = '{d: 0,   exp_w: 10, exp_sat: 0};
      tbl[1] = '{d: 5,   exp_w: 15, exp_sat: 0};
      tbl[2] = '{d: 9,   exp_w: 19, exp_sat: 0};
      tbl[3] = '{d: 10,  exp_w: 20, exp_sat: 0};
      tbl[4] = '{d: 11,  exp_w: 20, exp_sat: 1};
      tbl[5] = '{d: 50,  exp_w: 20, exp_sat: 1};
      tbl[6] = '{d: 0,   exp_w: 10, exp_sat: 0};
      tbl[7] = '{d: 255, exp_w: 20, exp_sat: 1};

      // Reset held with enable and a command present.
      reset = 1'b0; enable = 1'b1; dato = 8'd5;
      m_clear();
      repeat (5) cyc();
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_ancho", int'(ancho_actual), 0);
      reset = 1'b1;
      cyc();
      check("rise_latency_pwm", int'(pwm_out), 1);
      check("rise_latency_tick", int'(period_tick), 1);

      // Steady frames with command 5.
      for (int f = 0; f < 3; f++) begin
         if (f > 0) cyc();
         measure(hi, tk, -1, 0, -1);
         check("steady_high", hi, 15);
         check("steady_ticks", tk, 1);
         check("steady_sat", int'(sat), 0);
      end

      // Command-to-width table, including the clamp boundary.
      foreach (tbl[i]) begin
         dato = N'(tbl[i].d);
         sync_start("tbl");
         measure(hi, tk, -1, 0, -1);
         check("tbl_high", hi, tbl[i].exp_w);
         check("tbl_ancho", int'(ancho_actual), tbl[i].exp_w);
         check("tbl_sat", int'(sat), int'(tbl[i].exp_sat));
      end

      // Command changes mid-frame: applies only from the next frame.
      dato = 8'd3;
      sync_start("mid");
      measure(hi, tk, 5, 7, -1);
      check("mid_cur_high", hi, 13);
      cyc();
      measure(hi, tk, -1, 0, -1);
      check("mid_next_high", hi, 17);

      // Enable dropped at clock 40: frame completes, then idle.
      cyc();
      measure(hi, tk, -1, 0, 40);
      check("drop_high", hi, 17);
      hi2 = 0; tk2 = 0;
      repeat (10) begin
         cyc();
         hi2 += int'(pwm_out);
         tk2 += int'(period_tick);
      end
      check("idle_pwm", hi2, 0);
      check("idle_ticks", tk2, 0);
      check("idle_sat", int'(sat), 0);
      check("idle_ancho_hold", int'(ancho_actual), 17);
      enable = 1'b1;
      cyc();
      check("restart_pwm", int'(pwm_out), 1);
      check("restart_tick", int'(period_tick), 1);

      // Reset mid-pulse forces pwm low with no clock edge.
      repeat (4) cyc();
      check("pre_rst_pwm", int'(pwm_out), 1);
      #2;
      reset = 1'b0;
      m_clear();
      #1;
      check("async_rst_pwm", int'(pwm_out), 0);
      check("async_rst_ancho", int'(ancho_actual), 0);
      repeat (2) cyc();
      reset = 1'b1;
      cyc();
      measure(hi, tk, -1, 0, -1);
      check("post_rst_high", hi, 17);
      check("post_rst_ticks", tk, 1);
      cyc();
      check("frame_len_tick", int'(period_tick), 1);

      // Randomized run against the model.
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b0;
            m_clear();
            #1;
            compare_all("rnd_async");
            repeat ($urandom_range(1, 3)) cyc();
            reset = 1'b1;
         end
         if ($urandom_range(0, 59) == 0) enable = ~enable;
         if ($urandom_range(0, 19) == 0) dato = N'($urandom_range(0, 255));
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
